// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes, FSM states
// and a ceiling-log2 helper used to size counters and pointers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous word FIFO with power-of-two depth; a count register drives the
// full/empty flags and the occupancy output.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);

    localparam int PTR_W = clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo: DEPTH must be a power of two, at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // define which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state is always assigned with <= so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed from a word FIFO; frames are sent back to
// back while words are queued, and every output is driven from a register.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [DATA_BITS-1:0]        slowo_trans,
    input  logic                        start_trans,
    output logic                        transmisja,
    output logic                        wyjscie_trans,
    output logic                        pelny,
    output logic [clog2(FIFO_DEPTH):0]  liczba_slow
);

    localparam int BAUD_W = clog2(CLKS_PER_BIT);
    localparam int BIT_W  = clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    tx_state_t             state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  par_q;
    logic                  line_d;
    logic                  pop;
    logic                  write_req;
    logic                  fifo_empty;
    logic [DATA_BITS-1:0]  fifo_dout;
    logic                  baud_last;

    assign write_req = !start_trans;
    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (write_req),
        .pop   (pop),
        .din   (slowo_trans),
        .dout  (fifo_dout),
        .full  (pelny),
        .empty (fifo_empty),
        .count (liczba_slow)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        baud_d  = baud_last ? '0 : baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY == PAR_NONE) ? STOP : PAR;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PAR: begin
                if (baud_last) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            state_d = START;
                            pop     = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Line level is derived from the state being entered so it lands in a register.
        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_q[bit_d];
            PAR:     line_d = par_q;
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            baud_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            wyjscie_trans <= 1'b1;
            transmisja    <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            wyjscie_trans <= line_d;
            transmisja    <= (state_d != IDLE);
            if (pop) begin
                shift_q <= fifo_dout;
                par_q   <= (^fifo_dout) ^ (PARITY == PAR_ODD);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover even/odd/no parity and
// two stop bits; frames are decoded mid-bit and compared with hand-built vectors.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       CLK;
    logic       RST;
    logic       start_v [4];
    logic [8:0] data_v  [4];
    logic       busy_v  [4];
    logic       line_v  [4];
    logic       full_v  [4];
    logic [2:0] cnt_v   [4];
    logic [8:0] wbuf    [8];

    int n_checks = 0;
    int n_fail   = 0;

    // 0: 8 bits even parity, 1: 8 bits odd parity, 2: 8 bits no parity, 3: 7 bits even, 2 stops
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_even (
        .CLK(CLK), .RST(RST), .slowo_trans(data_v[0][7:0]), .start_trans(start_v[0]),
        .transmisja(busy_v[0]), .wyjscie_trans(line_v[0]), .pelny(full_v[0]), .liczba_slow(cnt_v[0]));
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_odd (
        .CLK(CLK), .RST(RST), .slowo_trans(data_v[1][7:0]), .start_trans(start_v[1]),
        .transmisja(busy_v[1]), .wyjscie_trans(line_v[1]), .pelny(full_v[1]), .liczba_slow(cnt_v[1]));
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_none (
        .CLK(CLK), .RST(RST), .slowo_trans(data_v[2][7:0]), .start_trans(start_v[2]),
        .transmisja(busy_v[2]), .wyjscie_trans(line_v[2]), .pelny(full_v[2]), .liczba_slow(cnt_v[2]));
    uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_stop2 (
        .CLK(CLK), .RST(RST), .slowo_trans(data_v[3][6:0]), .start_trans(start_v[3]),
        .transmisja(busy_v[3]), .wyjscie_trans(line_v[3]), .pelny(full_v[3]), .liczba_slow(cnt_v[3]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Expected line level per bit slot: slot 0 start, then data LSB first, parity, stops.
    function automatic logic [15:0] expected_frame(input int nbits, input logic [8:0] word,
                                                   input int pmode, input int stops);
        logic [15:0] v;
        int idx;
        int ones;
        v    = '0;
        idx  = 1;
        ones = 0;
        for (int i = 0; i < nbits; i++) begin
            v[idx] = word[i];
            ones += int'(word[i]);
            idx++;
        end
        if (pmode != 0) begin
            v[idx] = (pmode == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
            idx++;
        end
        for (int s = 0; s < stops; s++) begin
            v[idx] = 1'b1;
            idx++;
        end
        return v;
    endfunction

    task automatic write_words(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            data_v[d]  = wbuf[i];
            start_v[d] = 1'b0;
        end
        @(negedge CLK);
        start_v[d] = 1'b1;
    endtask

    // Waits for a start bit, then samples the middle of each bit slot.
    task automatic rx_frame(input int d, input int nslots, input int limit,
                            output logic [15:0] bits, output logic got);
        int w;
        w    = 0;
        bits = '0;
        got  = 1'b0;
        while (line_v[d] !== 1'b0 && w < limit) begin
            @(negedge CLK);
            w++;
        end
        if (line_v[d] === 1'b0) begin
            got = 1'b1;
            repeat (CPB / 2) @(negedge CLK);
            bits[0] = line_v[d];
            for (int j = 1; j < nslots; j++) begin
                repeat (CPB) @(negedge CLK);
                bits[j] = line_v[d];
            end
        end
    endtask

    task automatic measure_busy(input int d, input int wait_limit, input int max_len, output int len);
        int w;
        w   = 0;
        len = 0;
        while (busy_v[d] !== 1'b1 && w < wait_limit) begin
            @(negedge CLK);
            w++;
        end
        while (busy_v[d] === 1'b1 && len < max_len) begin
            len++;
            @(negedge CLK);
        end
    endtask

    task automatic run_single(input int d, input logic [8:0] word, input int nbits,
                              input int pmode, input int stops, input string tag);
        int nslots;
        nslots  = 1 + nbits + ((pmode != 0) ? 1 : 0) + stops;
        wbuf[0] = word;
        fork
            begin
                write_words(d, 1);
                check({tag, "_busy_after_push"}, busy_v[d], 0);
                check({tag, "_count_after_push"}, cnt_v[d], 1);
                @(negedge CLK);
                check({tag, "_line_first"}, line_v[d], 0);
                check({tag, "_busy_first"}, busy_v[d], 1);
                check({tag, "_count_after_pop"}, cnt_v[d], 0);
            end
            begin
                logic [15:0] bits;
                logic got;
                rx_frame(d, nslots, 20, bits, got);
                check({tag, "_frame_seen"}, got, 1);
                check({tag, "_frame_bits"}, bits, expected_frame(nbits, word, pmode, stops));
            end
            begin
                int len;
                measure_busy(d, 20, 400, len);
                check({tag, "_busy_len"}, len, nslots * CPB);
            end
        join
        check({tag, "_busy_end"}, busy_v[d], 0);
        check({tag, "_line_end"}, line_v[d], 1);
    endtask

    initial begin
        int exp_cnt [6];
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        RST = 1'b1;
        for (int d = 0; d < 4; d++) begin
            start_v[d] = 1'b1;
            data_v[d]  = '0;
        end
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset_line_%0d", d), line_v[d], 1);
            check($sformatf("reset_busy_%0d", d), busy_v[d], 0);
            check($sformatf("reset_full_%0d", d), full_v[d], 0);
            check($sformatf("reset_count_%0d", d), cnt_v[d], 0);
        end

        run_single(0, 9'h099, 8, 1, 1, "even_99");
        run_single(1, 9'h000, 8, 2, 1, "odd_00");
        run_single(2, 9'h0A5, 8, 0, 1, "none_a5");
        run_single(3, 9'h041, 7, 1, 2, "stop2_41");

        // Back-to-back frames from two consecutive writes.
        wbuf[0] = 9'h055;
        wbuf[1] = 9'h0AA;
        fork
            write_words(0, 2);
            begin
                logic [15:0] bits;
                logic got;
                rx_frame(0, 11, 20, bits, got);
                check("b2b_first_seen", got, 1);
                check("b2b_first_bits", bits, expected_frame(8, 9'h055, 1, 1));
                rx_frame(0, 11, 4, bits, got);
                check("b2b_second_seen", got, 1);
                check("b2b_second_bits", bits, expected_frame(8, 9'h0AA, 1, 1));
            end
            begin
                int len;
                measure_busy(0, 20, 400, len);
                check("b2b_busy_len", len, 88);
            end
        join
        check("b2b_busy_end", busy_v[0], 0);

        // Overflow: six writes into a depth-4 FIFO while the first frame drains one.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge CLK);
                    if (i > 0) begin
                        check($sformatf("ovf_count_w%0d", i), cnt_v[0], exp_cnt[i-1]);
                        check($sformatf("ovf_full_w%0d", i), full_v[0], (i >= 5) ? 1 : 0);
                    end
                    data_v[0]  = 9'(i + 1);
                    start_v[0] = 1'b0;
                end
                @(negedge CLK);
                start_v[0] = 1'b1;
                check("ovf_count_w6", cnt_v[0], exp_cnt[5]);
                check("ovf_full_w6", full_v[0], 1);
            end
            begin
                logic [15:0] bits;
                logic got;
                for (int f = 0; f < 5; f++) begin
                    rx_frame(0, 11, 20, bits, got);
                    check($sformatf("ovf_frame%0d_seen", f + 1), got, 1);
                    check($sformatf("ovf_frame%0d_bits", f + 1), bits, expected_frame(8, 9'(f + 1), 1, 1));
                end
            end
            begin
                int len;
                measure_busy(0, 20, 400, len);
                check("ovf_busy_len", len, 5 * 44);
            end
        join
        check("ovf_count_end", cnt_v[0], 0);
        check("ovf_full_end", full_v[0], 0);
        begin
            logic [15:0] bits;
            logic got;
            rx_frame(0, 11, 60, bits, got);
            check("ovf_no_sixth_frame", got, 0);
        end

        // Reset during the data bits of the first of three queued frames.
        wbuf[0] = 9'h011;
        wbuf[1] = 9'h022;
        wbuf[2] = 9'h033;
        write_words(0, 3);
        repeat (5) @(negedge CLK);
        check("rst_pre_busy", busy_v[0], 1);
        check("rst_pre_count", cnt_v[0], 2);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rst_line", line_v[0], 1);
        check("rst_busy", busy_v[0], 0);
        check("rst_count", cnt_v[0], 0);
        check("rst_full", full_v[0], 0);
        begin
            int hits;
            hits = 0;
            for (int i = 0; i < 80; i++) begin
                @(negedge CLK);
                if (busy_v[0] !== 1'b0 || line_v[0] !== 1'b1) hits++;
            end
            check("rst_stays_idle", hits, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
